// File: rtl/serial_data_receiver_if.sv
// Line and output-buffer signals between the serial receiver and its
// consumer. The slave side is the receiver itself; the master side drives
// the serial line and the read acknowledge.
interface serial_data_receiver_if #(
    parameter int DATA_WIDTH = 7
);
    logic                  serial_in;
    logic                  read_ack;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  frame_error;
    logic                  overrun;

    modport master (
        output serial_in,
        output read_ack,
        input  out_data,
        input  data_valid,
        input  parity_error,
        input  frame_error,
        input  overrun
    );

    modport slave (
        input  serial_in,
        input  read_ack,
        output out_data,
        output data_valid,
        output parity_error,
        output frame_error,
        output overrun
    );
endinterface

// File: rtl/serial_data_receiver.sv
// Serial frame receiver: one line bit per clock, frame is start, data
// MSB-first, parity, stop. A good frame lands in a one-entry buffer with a
// valid/ack handshake; a good frame arriving while the buffer is still
// unread is dropped and flagged as overrun. A zero stop bit pulses
// frame_error and discards the frame.
module serial_data_receiver #(
    parameter int DATA_WIDTH = 7,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_data_receiver_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  pending_perr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  data_valid_q;
    logic                  parity_error_q;
    logic                  frame_error_q;
    logic                  overrun_q;
    logic                  good_frame;
    logic                  take_word;

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a 1 on the idle line is a start bit, then DATA_WIDTH data
    // samples, one parity sample and one stop sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.serial_in) state_d = DATA;
            DATA:    if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = PARITY;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion decode: a good frame is loaded if the buffer is free or is
    // being read on this very edge; otherwise it is dropped.
    always_comb begin
        good_frame = (state_q == STOP) && bus.serial_in;
        take_word  = good_frame && (!data_valid_q || bus.read_ack);
    end

    // Bit counter, shift register and the parity verdict for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            shift_q        <= '0;
            pending_perr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.serial_in) cnt_q <= '0;
                end
                DATA: begin
                    shift_q <= {shift_q[DATA_WIDTH-2:0], bus.serial_in};
                    cnt_q   <= cnt_q + CW'(1);
                end
                PARITY: begin
                    pending_perr_q <= ((^shift_q) ^ PARITY_ODD) != bus.serial_in;
                end
                default: begin
                end
            endcase
        end
    end

    // Output buffer, handshake, overrun flag and the one-cycle frame error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            frame_error_q <= (state_q == STOP) && !bus.serial_in;
            if (take_word) begin
                out_data_q     <= shift_q;
                parity_error_q <= pending_perr_q;
                data_valid_q   <= 1'b1;
                if (bus.read_ack) overrun_q <= 1'b0;
            end else if (good_frame) begin
                overrun_q <= 1'b1;
            end else if (bus.read_ack && data_valid_q) begin
                data_valid_q   <= 1'b0;
                parity_error_q <= 1'b0;
                overrun_q      <= 1'b0;
            end
        end
    end

    assign bus.out_data     = out_data_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_serial_data_receiver.sv
// Bench for serial_data_receiver: directed frames from the test plan, a
// mid-frame reset, then randomized frames, gaps and acks, all compared
// against a frame-level model of the output buffer.
module tb_serial_data_receiver;
    localparam int DW         = 7;
    localparam bit PARITY_ODD = 1'b0;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    // Frame-level model of what the consumer should see.
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_perr;
    logic          m_overrun;

    serial_data_receiver_if #(.DATA_WIDTH(DW)) bus ();

    serial_data_receiver #(
        .DATA_WIDTH(DW),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBuffer(input string tag);
        checkOutput({tag, ".valid"}, 32'(bus.data_valid), 32'(m_valid));
        checkOutput({tag, ".data"}, 32'(bus.out_data), 32'(m_data));
        checkOutput({tag, ".perr"}, 32'(bus.parity_error), 32'(m_perr));
        checkOutput({tag, ".ovr"}, 32'(bus.overrun), 32'(m_overrun));
    endtask

    task automatic modelReset();
        m_data    = '0;
        m_valid   = 1'b0;
        m_perr    = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic modelAck();
        if (m_valid) begin
            m_valid   = 1'b0;
            m_perr    = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic modelFrame(input logic [DW-1:0] data, input logic perr,
                              input logic stop_bit, input logic ack);
        if (stop_bit) begin
            if (!m_valid || ack) begin
                m_valid = 1'b1;
                m_data  = data;
                m_perr  = perr;
                if (ack) m_overrun = 1'b0;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (ack) begin
            modelAck();
        end
    endtask

    // Drive one full frame bit by bit, optionally acking on the stop edge,
    // then check the buffer and the frame error right after the stop edge.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic flip_parity,
                                 input logic stop_bit, input logic ack_at_stop,
                                 input string tag);
        logic [DW+2:0] bits;
        logic          par_bit;
        logic          perr;
        par_bit = (^data) ^ PARITY_ODD ^ flip_parity;
        perr    = (((^data) ^ PARITY_ODD) != par_bit);
        bits    = {1'b1, data, par_bit, stop_bit};
        for (int i = 0; i < DW + 3; i++) begin
            @(negedge clk);
            if (i >= 1) checkOutput({tag, ".fe_low"}, 32'(bus.frame_error), 32'd0);
            if (i == DW + 2) begin
                checkBuffer({tag, ".pre"});
                bus.read_ack = ack_at_stop;
            end
            bus.serial_in = bits[DW+2-i];
        end
        @(negedge clk);
        modelFrame(data, perr, stop_bit, ack_at_stop);
        checkOutput({tag, ".fe"}, 32'(bus.frame_error), 32'(!stop_bit));
        checkBuffer({tag, ".post"});
        bus.read_ack  = 1'b0;
        bus.serial_in = 1'b0;
    endtask

    // Idle line for n cycles. ack_mode 0: no ack, 1: random acks,
    // 2: ack in the first cycle. The last cycle never acks.
    task automatic idleCycles(input int n, input int ack_mode, input string tag);
        logic pend;
        pend = 1'b0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (pend) modelAck();
            checkOutput({tag, ".fe_idle"}, 32'(bus.frame_error), 32'd0);
            checkBuffer(tag);
            if (j == n - 1)          pend = 1'b0;
            else if (ack_mode == 1)  pend = 1'($urandom_range(0, 1));
            else if (ack_mode == 2)  pend = (j == 0);
            else                     pend = 1'b0;
            bus.read_ack  = pend;
            bus.serial_in = 1'b0;
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        bus.serial_in = 1'b0;
        bus.read_ack  = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkBuffer("reset");
        checkOutput("reset.fe", 32'(bus.frame_error), 32'd0);
        rst = 1'b0;
        idleCycles(2, 1, "idle0");

        applyStimulus(7'h55, 1'b0, 1'b1, 1'b0, "f55");
        checkOutput("f55.const", 32'(bus.out_data), 32'h55);
        idleCycles(3, 2, "ack55");

        applyStimulus(7'h7F, 1'b0, 1'b1, 1'b0, "f7f");
        idleCycles(2, 2, "ack7f");
        applyStimulus(7'h01, 1'b0, 1'b1, 1'b0, "f01");
        idleCycles(2, 2, "ack01");

        applyStimulus(7'h55, 1'b1, 1'b1, 1'b0, "badpar");
        checkOutput("badpar.const", 32'(bus.parity_error), 32'd1);
        idleCycles(2, 2, "ackbp");

        applyStimulus(7'h03, 1'b0, 1'b0, 1'b0, "stop0");
        idleCycles(2, 0, "afterfe");
        applyStimulus(7'h03, 1'b0, 1'b1, 1'b0, "f03");
        idleCycles(2, 2, "ack03");

        applyStimulus(7'h12, 1'b0, 1'b1, 1'b0, "f12");
        idleCycles(1, 0, "gap12");
        applyStimulus(7'h34, 1'b0, 1'b1, 1'b0, "f34ovr");
        checkOutput("ovr.data", 32'(bus.out_data), 32'h12);
        checkOutput("ovr.flag", 32'(bus.overrun), 32'd1);
        idleCycles(3, 2, "ackovr");

        applyStimulus(7'h12, 1'b0, 1'b1, 1'b0, "f12b");
        idleCycles(1, 0, "gap12b");
        applyStimulus(7'h34, 1'b0, 1'b1, 1'b1, "f34ack");
        checkOutput("ackstop.data", 32'(bus.out_data), 32'h34);
        idleCycles(1, 0, "gap34");

        // Reset at the 4th data bit while a word is still buffered.
        @(negedge clk);
        bus.serial_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.serial_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkBuffer("midrst");
        checkOutput("midrst.fe", 32'(bus.frame_error), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.serial_in = 1'b0;
        idleCycles(1, 0, "postrst");
        applyStimulus(7'h2A, 1'b0, 1'b1, 1'b0, "f2a");
        idleCycles(2, 2, "ack2a");

        for (int k = 0; k < 40; k++) begin
            applyStimulus(7'($urandom), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), "rnd");
            idleCycles($urandom_range(0, 3), 1, "rndidle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
